// File: rtl/fan_pkg.sv
// Shared constants and types for the fan PWM generate/capture path.
package fan_pkg;

    localparam int FAN_PERIOD  = 1000;
    localparam int FAN_TIMEOUT = 2 * FAN_PERIOD;
    localparam int FAN_CNT_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } cap_state_e;

endpackage

// File: rtl/fan_sync.sv
// N-flop synchroniser for an asynchronous pin; reusable for any single-bit input.
module fan_sync #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] sync_r;

    // shift the raw pin through the synchroniser chain every clock
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[N-2:0], i_d};
        end
    end

    assign o_q = sync_r[N-1];

endmodule

// File: rtl/fan_pwm_capture.sv
// PWM capture: synchronises the pin, finds rising edges and measures period
// and high time in generator ticks, flagging a stuck line after a timeout.
module fan_pwm_capture
    import fan_pkg::*;
#(
    parameter int CNT_W       = FAN_CNT_W,
    parameter int TIMEOUT     = FAN_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic       lvl_s;
    logic       prev_r;
    logic       rise_s;
    cap_state_e state_r;
    logic [CNT_W-1:0] per_r;
    logic [CNT_W-1:0] hi_r;

    fan_sync #(.N(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_pwm),
        .o_q     (lvl_s)
    );

    assign rise_s  = lvl_s & ~prev_r;
    assign o_level = lvl_s;

    // one-clock delayed level for edge detection
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= lvl_s;
        end
    end

    // capture FSM, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            per_r        <= '0;
            hi_r         <= '0;
            o_period_cnt <= '0;
            o_high_cnt   <= '0;
            o_valid      <= 1'b0;
            o_stuck      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // the first partial period only arms the counters
                    if (rise_s) begin
                        state_r <= ST_MEASURE;
                        per_r   <= CNT_W'(i_tick);
                        hi_r    <= CNT_W'(i_tick);
                    end else begin
                        per_r <= per_r;
                    end
                end
                ST_MEASURE: begin
                    // a rise wins over both the tick increment and the timeout
                    if (rise_s) begin
                        o_period_cnt <= per_r;
                        o_high_cnt   <= hi_r;
                        o_valid      <= 1'b1;
                        per_r        <= CNT_W'(i_tick);
                        hi_r         <= CNT_W'(i_tick);
                    end else if (i_tick) begin
                        if (per_r == TIMEOUT_LAST) begin
                            state_r      <= ST_STUCK;
                            o_stuck      <= 1'b1;
                            o_period_cnt <= '0;
                            o_high_cnt   <= '0;
                        end else begin
                            per_r <= per_r + CNT_W'(1);
                            hi_r  <= hi_r + CNT_W'(lvl_s);
                        end
                    end else begin
                        per_r <= per_r;
                    end
                end
                ST_STUCK: begin
                    if (rise_s) begin
                        state_r <= ST_MEASURE;
                        o_stuck <= 1'b0;
                        per_r   <= CNT_W'(i_tick);
                        hi_r    <= CNT_W'(i_tick);
                    end else begin
                        per_r <= per_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    per_r   <= '0;
                    hi_r    <= '0;
                    o_stuck <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fan_pwm_capture.md
# fan_pwm_capture

Measures an external PWM signal, such as a fan's PWM input loop-back or a second controller's output, in units of the same tick that drives the fan PWM generator counter. It is the receive/decode end of the fan PWM path. It synchronises the asynchronous pin, detects rising edges, and counts period and high-time ticks. It reports one capture per PWM period and flags a stuck line (no rising edge) after a timeout.

## Interface
Parameters:
- `CNT_W`, 11: width of count outputs and internal counters.
- `TIMEOUT`, 2000: ticks without a rising edge before stuck is declared. Must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W − 1.
- `SYNC_STAGES`, 2: flip-flops in the input synchroniser. Must be ≥ 2.

Ports:
- `i_clk`, in, 1: system clock. This is the single clock.
- `i_reset`, in, 1: reset, asynchronous and active-high.
- `i_tick`, in, 1: one-cycle count enable, identical to the generator's counter step.
- `i_pwm`, in, 1: asynchronous PWM pin.
- `o_period_cnt`, out, CNT_W: ticks in the last complete period.
- `o_high_cnt`, out, CNT_W: ticks that were high in the last complete period.
- `o_valid`, out, 1: one-cycle pulse when new counts are latched.
- `o_stuck`, out, 1: high while the line is stuck (timeout reached).
- `o_level`, out, 1: synchronised pin level.

## Operation
- Synchroniser: SYNC_STAGES flops sampled on every clock, not gated by tick. `s_lvl` is the last stage. `s_prev` is `s_lvl` delayed by one clock. `rise = s_lvl & ~s_prev`.
- Reset values:
  - State = IDLE.
  - Synchroniser flops, `s_prev`, and the internal counters `per_c` and `hi_c` = 0.
  - All outputs = 0.
- IDLE: counters hold at 0 and `o_valid` stays 0.
  - On `rise`: go to MEASURE, load `per_c = i_tick`, load `hi_c = i_tick`.
  - The first partial period is never reported.
- MEASURE:
  - On `rise`:
    - Latch `o_period_cnt = per_c` and `o_high_cnt = hi_c`, using pre-increment values; the current cycle's tick is not included.
    - Assert `o_valid`.
    - Reload `per_c = i_tick` and `hi_c = i_tick`.
  - Otherwise, on `i_tick`:
    - `per_c += 1`.
    - `hi_c += s_lvl`.
  - When `per_c == TIMEOUT − 1` and `i_tick` is high with no `rise` in that cycle:
    - Go to STUCK with `o_stuck = 1`, `o_period_cnt = 0`, `o_high_cnt = 0`.
    - `o_valid` stays 0.
- STUCK: counters hold.
  - On `rise`: `o_stuck = 0`, go to MEASURE, load counters as in IDLE.
  - Last published counts remain 0 until the next full period completes.
- Simultaneous events:
  - `rise` has priority over timeout.
  - `rise` has priority over the tick increment.
- Arithmetic: counters cannot overflow, because the timeout fires before 2^CNT_W. `hi_c ≤ per_c` always.
- Reset asserted mid-period: all state clears at once and no `o_valid` is produced. After release, the next `rise` starts a new IDLE→MEASURE sequence.
- `o_level = s_lvl`. Consumers use it together with `o_stuck` to distinguish 0% duty (level low) from 100% duty (level high).

## Timing
- If `i_pwm` is first sampled high at clock edge k, `rise` is true in the cycle after edge k+SYNC_STAGES−1. `o_valid`, `o_period_cnt` and `o_high_cnt` update at edge k+SYNC_STAGES, so `o_valid` is high for exactly one cycle.
- `o_period_cnt` and `o_high_cnt` are stable between `o_valid` pulses.
- `o_stuck` rises at the clock edge on which the TIMEOUT-th tick after the last `rise` is counted.
- `o_stuck` falls at the clock edge on which MEASURE is entered.
- Capture is correct for tick-aligned PWM with a period ≥ 2 ticks and ≥ SYNC_STAGES+1 clocks per level.
- Throughput: one capture per PWM period. There is no back-pressure; consumers must sample on `o_valid`.

## Structure
- Shared package `fan_pkg`:
  - `FAN_PERIOD = 1000`, the generator period.
  - Default `TIMEOUT = 2*FAN_PERIOD`.
  - Default `CNT_W`.
  - State enum {IDLE, MEASURE, STUCK}.
- Sub-module `fan_sync` (parameterised N-flop synchroniser with reset). It is reusable for other pin inputs.
- Top level: the edge detector, the 3-state FSM, the two counters and the output registers.

## Test plan
- Reset, then generator-style PWM with period 1000 ticks and 300 high → no `o_valid` after the first rise; each subsequent rise gives `o_period_cnt=1000`, `o_high_cnt=300`, `o_valid` one cycle wide, exactly SYNC_STAGES clocks after the sampled rise.
- Duty change 300→999 then →1 high tick → the following captures report 1000/999, then 1000/1.
- Hold the pin low after a capture → `o_stuck=1` at the 2000th tick after the last rise, counts=0, `o_level=0`. Repeat with the pin held high → `o_level=1`. Resume PWM → `o_stuck` clears on the first rise, and the next full period reports correct counts.
- A rise in the same cycle as the 2000th tick → no stuck, capture reported (rise priority); a rise in the same cycle as a tick → latched value excludes that tick and the counters restart at 1.
- Assert `i_reset` mid-period → all outputs 0 on the same clock edge, no `o_valid`; after release, the first report comes only after two rises.
- Glitch-free random tick gaps (tick every 1–4 clocks) with 500/250 PWM → every capture reports 500/250.
